msg_schedule: RTL

SHA-256 message schedule expander: accepts one 512-bit block as sixteen 32-bit words over a valid/ready input stream and emits the 64 schedule words W0..W63 over a valid/ready output stream. It is the consumer of the small-sigma datapath: it applies σ1 (ROTR17 ^ ROTR19 ^ SHR10) and σ0 (ROTR7 ^ ROTR18 ^ SHR3) to a 16-word sliding window. It sits between the block padder and the compression round engine.

---
 rtl/msg_schedule.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/msg_schedule.sv
// SHA-256 message schedule expander: loads a 16-word block, then streams W0..W63.
// Optional OUT_IDX output is built when MSG_SCHED_IDX_EN is defined.
module msg_schedule (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [0:31] IN_W,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [0:31] OUT_W,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_LAST
`ifdef MSG_SCHED_IDX_EN
  ,
  output logic [5:0]  OUT_IDX
`endif
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned LOAD_LAST = 15;
  localparam int unsigned EXP_LAST  = 63;

  typedef enum logic {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WORD_W-1:0]  win_q [DEPTH];
  logic [WORD_W-1:0]  shift_word_c;
  logic [WORD_W-1:0]  gen_word_c;
  logic               shift_c;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
`ifdef MSG_SCHED_IDX_EN
  logic [CNT_W-1:0]   idx_q, idx_d;
`endif

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Next schedule word from the sliding window; additions wrap mod 2^32.
  assign gen_word_c = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  // Next-state, handshake and registered-output decode.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_c      = 1'b0;
    shift_word_c = '0;
    unique case (state_q)
      LOAD: begin
        if (IN_VALID && in_ready_q) begin
          shift_c      = 1'b1;
          shift_word_c = IN_W;
          if (count_q == CNT_W'(LOAD_LAST)) begin
            count_d = '0;
            state_d = EXPAND;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      EXPAND: begin
        if (OUT_READY && out_valid_q) begin
          shift_c      = 1'b1;
          shift_word_c = gen_word_c;
          if (count_q == CNT_W'(EXP_LAST)) begin
            count_d = '0;
            state_d = LOAD;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        count_d = '0;
      end
    endcase
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == EXPAND);
    out_last_d  = (state_d == EXPAND) && (count_d == CNT_W'(EXP_LAST));
`ifdef MSG_SCHED_IDX_EN
    idx_d       = (state_d == EXPAND) ? count_d : '0;
`endif
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= LOAD;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef MSG_SCHED_IDX_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef MSG_SCHED_IDX_EN
      idx_q       <= idx_d;
`endif
    end
  end

  // Sixteen-word window; entry 0 is the word currently presented.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        win_q[i] <= '0;
      end
    end else if (shift_c) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[DEPTH-1] <= shift_word_c;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_W     = win_q[0];
`ifdef MSG_SCHED_IDX_EN
  assign OUT_IDX   = idx_q;
`endif

endmodule
